// File: rtl/milano_pkg.sv
// Shared types and constants for the instruction fetch unit.
package milano_pkg;

  typedef enum logic [1:0] {
    IFU_IDLE,
    IFU_FETCH,
    IFU_FLUSH
  } ifu_state_e;

  localparam int unsigned IFU_DEPTH_DEFAULT = 2;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] rdata;
  } ifu_entry_t;

  // Instruction addresses are always word aligned.
  function automatic logic [31:0] ifu_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/ifu_fifo.sv
// Synchronous FIFO of ifu_entry_t with flush; flush takes priority over push/pop.
module ifu_fifo
  import milano_pkg::*;
#(
  parameter int unsigned Depth = IFU_DEPTH_DEFAULT
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   flush_i,
  input  logic                   push_i,
  input  ifu_entry_t             wdata_i,
  input  logic                   pop_i,
  output ifu_entry_t             rdata_o,
  output logic [$clog2(Depth):0] count_o,
  output logic                   empty_o,
  output logic                   full_o
);
  localparam int unsigned PtrW = $clog2(Depth);

  ifu_entry_t        r_mem [Depth];
  logic [PtrW-1:0]   r_wptr, r_rptr;
  logic [PtrW:0]     r_count;
  logic              w_push, w_pop;

  assign empty_o = (r_count == '0);
  assign full_o  = (r_count == (PtrW + 1)'(Depth));
  assign count_o = r_count;
  assign rdata_o = r_mem[r_rptr];
  assign w_push  = push_i & ~full_o;
  assign w_pop   = pop_i & ~empty_o;

  // Pointer and occupancy bookkeeping; Depth is a power of two so pointers wrap freely.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (flush_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (w_pop && !w_push) r_count <= r_count - 1'b1;
    end
  end

  // Storage needs no reset: consumers only look at it while the FIFO is non-empty.
  always_ff @(posedge clk_i) begin
    if (w_push && !flush_i) r_mem[r_wptr] <= wdata_i;
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: issues req/gnt/rvalid fetches, buffers words in a prefetch
// FIFO and presents them to IF-ID. Define IFU_BYPASS_EN for a zero-latency path from
// mem_rvalid_i to the IF-ID outputs when the FIFO is empty.
module instr_fetch_unit
  import milano_pkg::*;
#(
  parameter int unsigned DEPTH     = IFU_DEPTH_DEFAULT,
  parameter logic [31:0] BOOT_ADDR = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        fetch_en_i,
  input  logic        jump_valid_i,
  input  logic [31:0] jump_addr_i,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  output logic        if_valid_o,
  output logic [31:0] if_instr_rdata_o,
  output logic [31:0] if_instr_addr_o,
  input  logic        id_ready_i
);
  localparam int unsigned CntW = $clog2(DEPTH) + 1;

  ifu_state_e      r_state, w_state_d;
  logic [31:0]     r_pc, w_pc_d;
  logic [CntW-1:0] r_outst, w_outst_d, r_discard, w_discard_d;
  logic            r_req_hold, w_req_hold_d;
  logic [CntW:0]   w_credit_used;
  logic            w_gnt, w_keep, w_bypass;
  logic            w_fifo_push, w_fifo_pop, w_fifo_empty, w_fifo_full;
  logic [CntW-1:0] w_fifo_cnt, w_aq_cnt;
  logic            w_aq_push, w_aq_empty, w_aq_full;
  ifu_entry_t      w_fifo_wdata, w_fifo_head, w_aq_wdata, w_aq_head;
  logic            w_unused;

  // Buffered words plus in-flight requests never exceed DEPTH, so a push always fits.
  assign w_credit_used = {1'b0, w_fifo_cnt} + {1'b0, r_outst};
  assign mem_req_o     = (r_state == IFU_FETCH) &&
                         (r_req_hold || (fetch_en_i && (w_credit_used < (CntW + 1)'(DEPTH))));
  assign mem_addr_o    = r_pc;
  assign w_gnt         = mem_req_o & mem_gnt_i;
  assign w_keep        = mem_rvalid_i & (r_discard == '0) & ~jump_valid_i;

`ifdef IFU_BYPASS_EN
  assign w_bypass = w_keep & w_fifo_empty;
`else
  assign w_bypass = 1'b0;
`endif

  assign w_fifo_wdata = '{addr: w_aq_head.addr, rdata: mem_rdata_i};
  assign w_fifo_push  = w_keep & ~(w_bypass & id_ready_i);
  assign w_fifo_pop   = ~w_fifo_empty & id_ready_i & ~jump_valid_i;
  assign w_aq_wdata   = '{addr: r_pc, rdata: 32'h0};
  assign w_aq_push    = w_gnt & ~jump_valid_i;
  assign if_valid_o   = ~w_fifo_empty | w_bypass;
  assign w_unused     = ^{w_fifo_full, w_aq_full, w_aq_empty, w_aq_cnt, w_aq_head.rdata};

  // IF-ID outputs: FIFO head, or the live response when bypassing; zero when idle.
  always_comb begin
    if_instr_addr_o  = 32'h0;
    if_instr_rdata_o = 32'h0;
    if (w_bypass) begin
      if_instr_addr_o  = w_fifo_wdata.addr;
      if_instr_rdata_o = w_fifo_wdata.rdata;
    end else if (!w_fifo_empty) begin
      if_instr_addr_o  = w_fifo_head.addr;
      if_instr_rdata_o = w_fifo_head.rdata;
    end
  end

  // Next-state: counters, PC, held request and the IDLE/FETCH/FLUSH machine.
  always_comb begin
    w_outst_d = r_outst + CntW'(w_gnt) - CntW'(mem_rvalid_i);

    w_discard_d = r_discard;
    if (jump_valid_i) w_discard_d = w_outst_d;
    else if (mem_rvalid_i && (r_discard != '0)) w_discard_d = r_discard - 1'b1;

    w_pc_d = r_pc;
    if (jump_valid_i) w_pc_d = ifu_align(jump_addr_i);
    else if (w_gnt)   w_pc_d = r_pc + 32'd4;

    // An ungranted request stays up until granted; a redirect withdraws it.
    w_req_hold_d = mem_req_o & ~w_gnt & ~jump_valid_i;

    w_state_d = r_state;
    unique case (r_state)
      IFU_IDLE:  if (fetch_en_i) w_state_d = IFU_FETCH;
      IFU_FETCH: begin
        if (jump_valid_i && (w_outst_d != '0))  w_state_d = IFU_FLUSH;
        else if (!fetch_en_i && !w_req_hold_d) w_state_d = IFU_IDLE;
      end
      IFU_FLUSH: if (w_discard_d == '0) w_state_d = IFU_FETCH;
      default:   w_state_d = IFU_IDLE;
    endcase
  end

  // Control state registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state    <= IFU_IDLE;
      r_pc       <= BOOT_ADDR;
      r_outst    <= '0;
      r_discard  <= '0;
      r_req_hold <= 1'b0;
    end else begin
      r_state    <= w_state_d;
      r_pc       <= w_pc_d;
      r_outst    <= w_outst_d;
      r_discard  <= w_discard_d;
      r_req_hold <= w_req_hold_d;
    end
  end

  ifu_fifo #(.Depth(DEPTH)) u_prefetch_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush_i (jump_valid_i),
    .push_i  (w_fifo_push),
    .wdata_i (w_fifo_wdata),
    .pop_i   (w_fifo_pop),
    .rdata_o (w_fifo_head),
    .count_o (w_fifo_cnt),
    .empty_o (w_fifo_empty),
    .full_o  (w_fifo_full)
  );

  // Addresses of granted, not-yet-answered requests, in issue order.
  ifu_fifo #(.Depth(DEPTH)) u_addr_queue (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush_i (jump_valid_i),
    .push_i  (w_aq_push),
    .wdata_i (w_aq_wdata),
    .pop_i   (w_keep),
    .rdata_o (w_aq_head),
    .count_o (w_aq_cnt),
    .empty_o (w_aq_empty),
    .full_o  (w_aq_full)
  );

endmodule
